// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared sizes, command encoding and sequencer states for cam_ctrl
package cam_pkg;

    localparam int DEPTH = 16;
    localparam int WIDTH = 7;
    localparam int IDXW  = 4;

    typedef enum logic [1:0] {
        OP_NOP    = 2'd0,
        OP_WRITE  = 2'd1,
        OP_SEARCH = 2'd2,
        OP_CLEAR  = 2'd3
    } cam_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_SEARCH  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_CLEAR   = 3'd4,
        ST_RESP    = 3'd5
    } cam_state_e;

endpackage

// File: rtl/cam_match_encoder.sv
// rtl/cam_match_encoder.sv - hit, multi-hit and lowest-index priority encode of a match mask
module cam_match_encoder
    import cam_pkg::*;
(
    input  logic [DEPTH-1:0] mask,
    output logic             hit,
    output logic             multi,
    output logic [IDXW-1:0]  index
);

    localparam logic [DEPTH-1:0] ONE = DEPTH'(1);

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    always_comb begin
        hit   = |mask;
        multi = |(mask & (mask - ONE));
        index = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                index = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/cam_ctrl.sv
// rtl/cam_ctrl.sv - command sequencer, occupancy tracker and response encoder for the cam array
module cam_ctrl
    import cam_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic             rsp_multi,
    output logic [IDXW-1:0]  rsp_index,
    output logic             rsp_evict,
    output logic [DEPTH-1:0] rsp_mask,
    output logic             cam_we,
    output logic [WIDTH-1:0] cam_content,
    output logic             cam_rst_n,
    input  logic [DEPTH-1:0] cam_found
);

    cam_state_e       state;
    cam_state_e       state_n;
    logic [DEPTH-1:0] valid;
    logic [IDXW-1:0]  ptr;
    logic [DEPTH-1:0] match_mask;
    logic             enc_hit;
    logic             enc_multi;
    logic [IDXW-1:0]  enc_index;
    logic             accept;

    assign accept     = cmd_valid & cmd_ready;
    // The array has no notion of empty slots, so raw matches are qualified by occupancy.
    assign match_mask = cam_found & valid;

    cam_match_encoder u_encoder (
        .mask  (match_mask),
        .hit   (enc_hit),
        .multi (enc_multi),
        .index (enc_index)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state: one command in flight, SEARCH waits a cycle for the array's registered compare.
    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    unique case (cam_op_e'(cmd_op))
                        OP_WRITE:  state_n = ST_WRITE;
                        OP_SEARCH: state_n = ST_SEARCH;
                        OP_CLEAR:  state_n = ST_CLEAR;
                        default:   state_n = ST_IDLE;
                    endcase
                end
            end
            ST_WRITE:   state_n = ST_RESP;
            ST_SEARCH:  state_n = ST_CAPTURE;
            ST_CAPTURE: state_n = ST_RESP;
            ST_CLEAR:   state_n = ST_RESP;
            ST_RESP:    state_n = rsp_ready ? ST_IDLE : ST_RESP;
            default:    state_n = ST_IDLE;
        endcase
    end

    // Handshake and write-enable outputs decoded from the current state.
    always_comb begin
        cmd_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
        cam_we    = (state == ST_WRITE);
    end

    // Array drive: content latched on accept; array reset held low during CLEAR so it sees one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cam_content <= '0;
            cam_rst_n   <= 1'b0;
        end else begin
            cam_rst_n <= (state_n != ST_CLEAR);
            if (accept) begin
                cam_content <= cmd_data;
            end
        end
    end

    // Occupancy mask and write pointer, kept in step with the array's one-hot pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            ptr   <= '0;
        end else if (state == ST_WRITE) begin
            valid[ptr] <= 1'b1;
            ptr        <= (ptr == IDXW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end else if (state == ST_CLEAR) begin
            valid <= '0;
            ptr   <= '0;
        end
    end

    // Response fields are loaded in the working state and held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_hit   <= 1'b0;
            rsp_multi <= 1'b0;
            rsp_index <= '0;
            rsp_evict <= 1'b0;
            rsp_mask  <= '0;
        end else begin
            unique case (state)
                ST_WRITE: begin
                    rsp_hit   <= 1'b0;
                    rsp_multi <= 1'b0;
                    rsp_index <= ptr;
                    rsp_evict <= valid[ptr];
                    rsp_mask  <= '0;
                end
                ST_CAPTURE: begin
                    rsp_hit   <= enc_hit;
                    rsp_multi <= enc_multi;
                    rsp_index <= enc_index;
                    rsp_evict <= 1'b0;
                    rsp_mask  <= match_mask;
                end
                ST_CLEAR: begin
                    rsp_hit   <= 1'b0;
                    rsp_multi <= 1'b0;
                    rsp_index <= '0;
                    rsp_evict <= 1'b0;
                    rsp_mask  <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_ctrl.sv
// tb/tb_cam_ctrl.sv - directed table-driven bench for cam_ctrl with a behavioural cam array
module tb_cam_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [6:0]  cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;
    logic        rsp_multi;
    logic [3:0]  rsp_index;
    logic        rsp_evict;
    logic [15:0] rsp_mask;
    logic        cam_we;
    logic [6:0]  cam_content;
    logic        cam_rst_n;
    logic [15:0] cam_found;

    localparam logic [1:0] W = 2'd1;
    localparam logic [1:0] S = 2'd2;
    localparam logic [1:0] C = 2'd3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cam_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_hit     (rsp_hit),
        .rsp_multi   (rsp_multi),
        .rsp_index   (rsp_index),
        .rsp_evict   (rsp_evict),
        .rsp_mask    (rsp_mask),
        .cam_we      (cam_we),
        .cam_content (cam_content),
        .cam_rst_n   (cam_rst_n),
        .cam_found   (cam_found)
    );

    // Behavioural array: sync reset, one-hot style write pointer, registered compare.
    logic [6:0]  arr [16];
    logic [3:0]  aptr;
    always @(posedge clk) begin
        if (!cam_rst_n) begin
            for (int i = 0; i < 16; i++) arr[i] <= 7'd0;
            aptr <= 4'd0;
        end else if (cam_we) begin
            arr[aptr] <= cam_content;
            aptr      <= aptr + 4'd1;
        end
        for (int i = 0; i < 16; i++) cam_found[i] <= (arr[i] == cam_content);
    end

    // Edge counters for write pulses and array-reset edges while out of reset.
    int we_cnt = 0;
    int rl_cnt = 0;
    always @(posedge clk) begin
        if (rst_n) begin
            if (cam_we)     we_cnt <= we_cnt + 1;
            if (!cam_rst_n) rl_cnt <= rl_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  data;
        logic        hit;
        logic        multi;
        logic [3:0]  idx;
        logic        evict;
        logic [15:0] mask;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] op, input logic [6:0] d, input logic h,
                                input logic m, input logic [3:0] i, input logic e,
                                input logic [15:0] k);
        vec_t v;
        v.op = op; v.data = d; v.hit = h; v.multi = m; v.idx = i; v.evict = e; v.mask = k;
        return v;
    endfunction

    // Response captured by issue().
    logic        r_hit, r_multi, r_evict;
    logic [3:0]  r_idx;
    logic [15:0] r_mask;
    int          r_lat, r_we, r_rl;

    task automatic issue(input logic [1:0] op, input logic [6:0] data, input int stall);
        int n;
        int we0, rl0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        rsp_ready = (stall == 0);
        we0 = we_cnt;
        rl0 = rl_cnt;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            errors++;
            $display("FAIL accept_timeout: cmd_ready stayed 0 for %0d cycles", n);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        r_lat = 1;
        while (!rsp_valid && r_lat < 20) begin
            @(posedge clk);
            #1;
            r_lat++;
        end
        if (!rsp_valid) begin
            errors++;
            $display("FAIL rsp_timeout: rsp_valid stayed 0 for %0d cycles", r_lat);
        end
        r_hit = rsp_hit; r_multi = rsp_multi; r_idx = rsp_index;
        r_evict = rsp_evict; r_mask = rsp_mask;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("stall_we", 32'(cam_we), 32'd0);
            chk("stall_fields", {10'd0, rsp_hit, rsp_multi, rsp_index, rsp_evict, rsp_mask},
                {10'd0, r_hit, r_multi, r_idx, r_evict, r_mask});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        chk("ready_back", 32'(cmd_ready), 32'd1);
        r_we = we_cnt - we0;
        r_rl = rl_cnt - rl0;
    endtask

    task automatic check_rsp(input vec_t v, input int tag);
        string t;
        t = $sformatf("v%0d", tag);
        chk({t, "_lat"}, 32'(r_lat), (v.op == S) ? 32'd3 : 32'd2);
        chk({t, "_we_pulses"}, 32'(r_we), (v.op == W) ? 32'd1 : 32'd0);
        chk({t, "_rst_edges"}, 32'(r_rl), (v.op == C) ? 32'd1 : 32'd0);
        chk({t, "_index"}, 32'(r_idx), 32'(v.idx));
        if (v.op == W) chk({t, "_evict"}, 32'(r_evict), 32'(v.evict));
        if (v.op == S) begin
            chk({t, "_hit"}, 32'(r_hit), 32'(v.hit));
            chk({t, "_multi"}, 32'(r_multi), 32'(v.multi));
            chk({t, "_mask"}, 32'(r_mask), 32'(v.mask));
        end
    endtask

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed command table with hand-computed responses.
        vecs.push_back(mk(S, 7'h00, 0, 0, 4'd0, 0, 16'h0000));
        vecs.push_back(mk(W, 7'h11, 0, 0, 4'd0, 0, 16'h0000));
        vecs.push_back(mk(W, 7'h22, 0, 0, 4'd1, 0, 16'h0000));
        vecs.push_back(mk(S, 7'h22, 1, 0, 4'd1, 0, 16'h0002));
        vecs.push_back(mk(C, 7'h00, 0, 0, 4'd0, 0, 16'h0000));
        vecs.push_back(mk(W, 7'h05, 0, 0, 4'd0, 0, 16'h0000));
        vecs.push_back(mk(W, 7'h40, 0, 0, 4'd1, 0, 16'h0000));
        vecs.push_back(mk(W, 7'h41, 0, 0, 4'd2, 0, 16'h0000));
        vecs.push_back(mk(W, 7'h05, 0, 0, 4'd3, 0, 16'h0000));
        vecs.push_back(mk(W, 7'h42, 0, 0, 4'd4, 0, 16'h0000));
        vecs.push_back(mk(W, 7'h43, 0, 0, 4'd5, 0, 16'h0000));
        vecs.push_back(mk(W, 7'h44, 0, 0, 4'd6, 0, 16'h0000));
        vecs.push_back(mk(W, 7'h05, 0, 0, 4'd7, 0, 16'h0000));
        vecs.push_back(mk(S, 7'h05, 1, 1, 4'd0, 0, 16'h0089));
        vecs.push_back(mk(C, 7'h00, 0, 0, 4'd0, 0, 16'h0000));
        for (int i = 0; i <= 16; i++)
            vecs.push_back(mk(W, 7'(i), 0, 0, 4'(i % 16), (i == 16), 16'h0000));
        vecs.push_back(mk(S, 7'h00, 0, 0, 4'd0, 0, 16'h0000));
        vecs.push_back(mk(S, 7'h10, 1, 0, 4'd0, 0, 16'h0001));
        vecs.push_back(mk(S, 7'h0F, 1, 0, 4'd15, 0, 16'h8000));
        vecs.push_back(mk(W, 7'h70, 0, 0, 4'd1, 1, 16'h0000));
        vecs.push_back(mk(S, 7'h01, 0, 0, 4'd0, 0, 16'h0000));

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 7'd0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_fields", {10'd0, rsp_hit, rsp_multi, rsp_index, rsp_evict, rsp_mask}, 32'd0);
        chk("reset_we", 32'(cam_we), 32'd0);
        chk("reset_content", 32'(cam_content), 32'd0);
        chk("reset_cam_rst_n", 32'(cam_rst_n), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("cam_rst_n_rise", 32'(cam_rst_n), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].op, vecs[i].data, 0);
            check_rsp(vecs[i], i);
        end

        // Back-pressured SEARCH response; slot 3 holds 3 from the fill sequence.
        issue(S, 7'h03, 5);
        chk("stall_hit", 32'(r_hit), 32'd1);
        chk("stall_index", 32'(r_idx), 32'd3);
        chk("stall_mask", 32'(r_mask), 32'h0008);
        chk("stall_we_pulses", 32'(r_we), 32'd0);

        // CLEAR after four writes.
        issue(C, 7'h00, 0);
        for (int i = 0; i < 4; i++) begin
            issue(W, 7'(8'h61 + i), 0);
            chk("cl_wr_index", 32'(r_idx), 32'(i));
        end
        issue(C, 7'h00, 0);
        chk("cl_rst_edges", 32'(r_rl), 32'd1);
        issue(S, 7'h62, 0);
        chk("cl_search_hit", 32'(r_hit), 32'd0);
        chk("cl_search_mask", 32'(r_mask), 32'h0000);
        issue(S, 7'h00, 0);
        chk("cl_zero_hit", 32'(r_hit), 32'd0);
        issue(W, 7'h33, 0);
        chk("cl_wr_index0", 32'(r_idx), 32'd0);
        chk("cl_wr_evict", 32'(r_evict), 32'd0);

        // Reset while a WRITE response is pending.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = W; cmd_data = 7'h55; rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_op = 2'd0;
        @(posedge clk);
        #1;
        chk("midop_pending", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midop_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midop_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midop_index", 32'(rsp_index), 32'd0);
        chk("midop_cam_rst_n", 32'(cam_rst_n), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; rsp_ready = 1'b1;
        issue(S, 7'h55, 0);
        chk("midop_search_hit", 32'(r_hit), 32'd0);
        issue(W, 7'h55, 0);
        chk("midop_wr_index", 32'(r_idx), 32'd0);
        chk("midop_wr_evict", 32'(r_evict), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
